// File: rtl/i2s_master_clkgen.sv
// i2s_master_clkgen: master-side I2S SCK/WS sequencer.
// Divides clk_i down to SCK, counts bits per word to drive WS, and emits
// per-bit and per-word strobes for the TX/RX datapath. Every line and strobe
// is registered so a strobe is high in the same cycle the SCK edge shows.
// Optional feature macro: I2S_FRAME_CNT_EN (frame counter with auto-stop).
module i2s_master_clkgen #(
  parameter int DIV_W  = 16,
  parameter int WLEN_W = 5
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              cfg_en_i,
  input  logic [DIV_W-1:0]  cfg_div_i,
  input  logic [WLEN_W-1:0] cfg_wlen_i,
  input  logic              cfg_ws_dly_i,
`ifdef I2S_FRAME_CNT_EN
  input  logic [15:0]       cfg_frames_i,
  output logic [15:0]       frame_cnt_o,
`endif
  output logic              sck_o,
  output logic              sck_oe_o,
  output logic              ws_o,
  output logic              ws_oe_o,
  output logic              busy_o,
  output logic              bit_rise_o,
  output logic              bit_fall_o,
  output logic              word_end_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  localparam logic [WLEN_W-1:0] WLEN_ONE = WLEN_W'(1);

  state_e state_q, state_d;

  // Configuration captured when leaving IDLE; frozen for the whole run.
  logic [DIV_W-1:0]  div_q, div_d;
  logic [WLEN_W-1:0] wlen_q, wlen_d;
  logic              ws_dly_q, ws_dly_d;

  // Timing state.
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [WLEN_W-1:0] bit_cnt_q, bit_cnt_d;
  logic              word_sel_q, word_sel_d;   // 0 = left word, 1 = right word

  // Registered outputs.
  logic sck_q, sck_d;
  logic ws_q, ws_d;
  logic oe_q, oe_d;
  logic bit_rise_q, bit_rise_d;
  logic bit_fall_q, bit_fall_d;
  logic word_end_q, word_end_d;

  logic tick;        // divider terminal count this cycle
  logic running;     // SCK toggling states
  logic fall_now;    // this tick produces a falling SCK edge
  logic bit_wrap;    // falling edge that closes the current word
  logic right_end;   // falling edge that closes a right word (frame end)
  logic limit_hit;   // frame limit reached on this frame end
  logic start_ok;    // IDLE may launch a new run
  logic shutdown;    // this frame end returns the block to IDLE

  logic [WLEN_W-1:0] wlen_eff;
  logic [WLEN_W-1:0] wlen_m1;

`ifdef I2S_FRAME_CNT_EN
  logic [15:0] frames_q, frames_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        need_low_q, need_low_d;    // auto-stop happened; wait for en low
`endif

  // A word length of one bit is not a usable word; treat it as two.
  assign wlen_eff = (cfg_wlen_i == '0) ? WLEN_ONE : cfg_wlen_i;
  assign wlen_m1  = wlen_q - WLEN_ONE;

  assign tick      = (div_cnt_q == div_q);
  assign running   = (state_q == ST_RUN) || (state_q == ST_STOP);
  assign fall_now  = running && tick && sck_q;
  assign bit_wrap  = fall_now && (bit_cnt_q == wlen_q);
  assign right_end = bit_wrap && word_sel_q;

`ifdef I2S_FRAME_CNT_EN
  assign limit_hit = right_end && (frames_q != '0) &&
                     ((frame_cnt_q + 16'd1) == frames_q);
  assign start_ok  = cfg_en_i && !need_low_q;
`else
  assign limit_hit = 1'b0;
  assign start_ok  = cfg_en_i;
`endif

  assign shutdown = right_end &&
                    ((state_q == ST_STOP) || ((state_q == ST_RUN) && limit_hit));

  // State register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_ok) state_d = ST_START;
      end
      ST_START: begin
        // START always hands over to RUN; a dropped enable is seen there.
        if (tick) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (shutdown)       state_d = ST_IDLE;
        else if (!cfg_en_i) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (shutdown) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next-value logic: divider, edges, bit and word tracking.
  always_comb begin
    div_d      = div_q;
    wlen_d     = wlen_q;
    ws_dly_d   = ws_dly_q;
    div_cnt_d  = div_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    word_sel_d = word_sel_q;
    sck_d      = sck_q;
    ws_d       = ws_q;
    oe_d       = oe_q;
    bit_rise_d = 1'b0;
    bit_fall_d = 1'b0;
    word_end_d = 1'b0;
`ifdef I2S_FRAME_CNT_EN
    frames_d    = frames_q;
    frame_cnt_d = frame_cnt_q;
    need_low_d  = need_low_q;
    if (!cfg_en_i)      need_low_d = 1'b0;
    else if (limit_hit) need_low_d = 1'b1;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          div_d      = cfg_div_i;
          wlen_d     = wlen_eff;
          ws_dly_d   = cfg_ws_dly_i;
          oe_d       = 1'b1;
          div_cnt_d  = '0;
          bit_cnt_d  = '0;
          word_sel_d = 1'b0;
          sck_d      = 1'b0;
          ws_d       = 1'b0;
`ifdef I2S_FRAME_CNT_EN
          frames_d    = cfg_frames_i;
          frame_cnt_d = '0;
`endif
        end
      end

      ST_START: begin
        // One half-period of SCK low before the divider starts toggling.
        div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
`ifdef I2S_FRAME_CNT_EN
        frame_cnt_d = '0;
`endif
      end

      ST_RUN, ST_STOP: begin
        div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
        if (tick) begin
          sck_d = ~sck_q;
          if (sck_q) begin
            bit_fall_d = 1'b1;
            if (bit_wrap) begin
              bit_cnt_d  = '0;
              word_end_d = 1'b1;
              word_sel_d = ~word_sel_q;
              if (!ws_dly_q) ws_d = ~ws_q;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
              // Philips mode: WS moves one bit ahead of the word boundary.
              if (ws_dly_q && (bit_cnt_q == wlen_m1)) ws_d = ~ws_q;
            end
          end else begin
            bit_rise_d = 1'b1;
          end
        end
`ifdef I2S_FRAME_CNT_EN
        if (right_end) frame_cnt_d = frame_cnt_q + 16'd1;
`endif
        // Final frame edge: park both lines low and release the pads.
        if (shutdown) begin
          ws_d       = 1'b0;
          oe_d       = 1'b0;
          div_cnt_d  = '0;
          bit_cnt_d  = '0;
          word_sel_d = 1'b0;
        end
      end

      default: ;
    endcase
  end

  // Datapath and output registers; reset drops the lines immediately.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      div_q      <= '0;
      wlen_q     <= '0;
      ws_dly_q   <= 1'b0;
      div_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      word_sel_q <= 1'b0;
      sck_q      <= 1'b0;
      ws_q       <= 1'b0;
      oe_q       <= 1'b0;
      bit_rise_q <= 1'b0;
      bit_fall_q <= 1'b0;
      word_end_q <= 1'b0;
    end else begin
      div_q      <= div_d;
      wlen_q     <= wlen_d;
      ws_dly_q   <= ws_dly_d;
      div_cnt_q  <= div_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      word_sel_q <= word_sel_d;
      sck_q      <= sck_d;
      ws_q       <= ws_d;
      oe_q       <= oe_d;
      bit_rise_q <= bit_rise_d;
      bit_fall_q <= bit_fall_d;
      word_end_q <= word_end_d;
    end
  end

`ifdef I2S_FRAME_CNT_EN
  // Frame counter, latched limit and restart interlock.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      frames_q    <= '0;
      frame_cnt_q <= '0;
      need_low_q  <= 1'b0;
    end else begin
      frames_q    <= frames_d;
      frame_cnt_q <= frame_cnt_d;
      need_low_q  <= need_low_d;
    end
  end

  assign frame_cnt_o = frame_cnt_q;
`endif

  assign sck_o      = sck_q;
  assign sck_oe_o   = oe_q;
  assign ws_o       = ws_q;
  assign ws_oe_o    = oe_q;
  assign busy_o     = (state_q != ST_IDLE);
  assign bit_rise_o = bit_rise_q;
  assign bit_fall_o = bit_fall_q;
  assign word_end_o = word_end_q;

endmodule

// File: tb/tb_i2s_master_clkgen.sv
// Self-checking bench for i2s_master_clkgen. Expected events (cycle offset
// from START entry plus the value of interest) are queued before a run and
// popped as the DUT produces them.
`timescale 1ns/1ps
module tb_i2s_master_clkgen;
  localparam int DIV_W  = 16;
  localparam int WLEN_W = 5;

  localparam int EV_WE   = 0;
  localparam int EV_WS   = 1;
  localparam int EV_RISE = 2;

  logic              clk  = 1'b0;
  logic              rstn = 1'b0;
  logic              en   = 1'b0;
  logic [DIV_W-1:0]  div  = '0;
  logic [WLEN_W-1:0] wlen = '0;
  logic              dly  = 1'b0;
  logic sck, sck_oe, ws, ws_oe, busy, rise, fall, wend;
`ifdef I2S_FRAME_CNT_EN
  logic [15:0] frames = '0;
  logic [15:0] fcnt;
`endif

  typedef struct {
    int kind;
    int off;
    int val;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic ws_prev  = 1'b0;

  i2s_master_clkgen #(.DIV_W(DIV_W), .WLEN_W(WLEN_W)) dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .cfg_en_i     (en),
    .cfg_div_i    (div),
    .cfg_wlen_i   (wlen),
    .cfg_ws_dly_i (dly),
`ifdef I2S_FRAME_CNT_EN
    .cfg_frames_i (frames),
    .frame_cnt_o  (fcnt),
`endif
    .sck_o        (sck),
    .sck_oe_o     (sck_oe),
    .ws_o         (ws),
    .ws_oe_o      (ws_oe),
    .busy_o       (busy),
    .bit_rise_o   (rise),
    .bit_fall_o   (fall),
    .word_end_o   (wend)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one clock and sample 1ns after the active edge.
  task automatic tick();
    ws_prev = ws;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push(input int kind, input int off, input int val);
    exp_t e;
    e.kind = kind;
    e.off  = off;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    ok = !busy;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    en   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({sck, sck_oe, ws, ws_oe, busy, rise, fall, wend} !== 8'b0) begin
      n_fail++;
      $display("FAIL reset_hold: outputs=%b, expected 00000000",
               {sck, sck_oe, ws, ws_oe, busy, rise, fall, wend});
    end
    rstn = 1'b1;
    tick();
    tick();
    n_checks++;
    if (busy !== 1'b0 || sck_oe !== 1'b0 || sck !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b sck_oe=%b sck=%b, expected 0 0 0", busy, sck_oe, sck);
    end
  endtask

  task automatic test_divider();
    exp_t e;
    int t0, first_rise, prev_rise, n;
    bit ok;
    exp_q.delete();
    div = 0; wlen = 15; dly = 0; en = 1'b1;
    for (int j = 1; j <= 3; j++) push(EV_WE, 32 * j + 1, j % 2);
    tick();
    t0 = cyc;
    n_checks++;
    if (busy !== 1'b1 || sck_oe !== 1'b1 || ws_oe !== 1'b1) begin
      n_fail++;
      $display("FAIL divider_start: busy=%b sck_oe=%b ws_oe=%b, expected 1 1 1", busy, sck_oe, ws_oe);
    end
    first_rise = -1; prev_rise = -1; n = 0;
    while (exp_q.size() > 0 && n < 300) begin
      tick();
      n++;
      if (rise) begin
        n_checks++;
        if (first_rise < 0) begin
          first_rise = cyc - t0;
          if (first_rise != 2) begin
            n_fail++;
            $display("FAIL divider_first_rise: offset=%0d, expected 2", first_rise);
          end
        end else if (cyc - prev_rise != 2) begin
          n_fail++;
          $display("FAIL divider_period: gap=%0d, expected 2", cyc - prev_rise);
        end
        prev_rise = cyc;
      end
      if (wend && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (cyc - t0 != e.off || int'(ws) != e.val) begin
          n_fail++;
          $display("FAIL divider_word_end: offset=%0d ws=%b, expected offset=%0d ws=%0d",
                   cyc - t0, ws, e.off, e.val);
        end
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL divider_timeout: %0d word ends missing, expected 0", exp_q.size());
    end
    en = 1'b0;
    wait_idle(400, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL divider_stop: busy=%b, expected 0", busy);
    end
  endtask

  task automatic test_philips();
    exp_t e;
    int t0, n, rises, we_n;
    bit ok;
    exp_q.delete();
    div = 3; wlen = 7; dly = 1; en = 1'b1;
    push(EV_WS, 60, 1);
    push(EV_WE, 68, 1);
    push(EV_WS, 124, 0);
    push(EV_WE, 132, 0);
    tick();
    t0 = cyc; n = 0; rises = 0; we_n = 0;
    while (exp_q.size() > 0 && n < 400) begin
      tick();
      n++;
      if (rise) rises++;
      if (ws !== ws_prev && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (e.kind != EV_WS || cyc - t0 != e.off || int'(ws) != e.val) begin
          n_fail++;
          $display("FAIL philips_ws: kind=%0d offset=%0d ws=%b, expected kind=%0d offset=%0d ws=%0d",
                   EV_WS, cyc - t0, ws, e.kind, e.off, e.val);
        end
      end
      if (wend && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        we_n++;
        n_checks++;
        if (e.kind != EV_WE || cyc - t0 != e.off || int'(ws) != e.val) begin
          n_fail++;
          $display("FAIL philips_word_end: kind=%0d offset=%0d ws=%b, expected kind=%0d offset=%0d ws=%0d",
                   EV_WE, cyc - t0, ws, e.kind, e.off, e.val);
        end
        if (we_n == 2) begin
          n_checks++;
          if (rises != 16) begin
            n_fail++;
            $display("FAIL philips_rises_per_frame: got %0d, expected 16", rises);
          end
        end
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL philips_timeout: %0d events missing, expected 0", exp_q.size());
    end
    en = 1'b0;
    wait_idle(400, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL philips_stop: busy=%b, expected 0", busy);
    end
  endtask

  task automatic test_clean_stop();
    exp_t e;
    int t0, n, falls;
    exp_q.delete();
    div = 0; wlen = 7; dly = 0; en = 1'b1;
    push(EV_WE, 17, 1);
    push(EV_WE, 33, 0);
    tick();
    t0 = cyc; n = 0; falls = 0;
    while (exp_q.size() > 0 && n < 200) begin
      tick();
      n++;
      if (fall) falls++;
      // Left word, bit 3 in flight: request the stop here.
      if (cyc - t0 == 7) en = 1'b0;
      if (wend && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (cyc - t0 != e.off || int'(ws) != e.val) begin
          n_fail++;
          $display("FAIL stop_word_end: offset=%0d ws=%b, expected offset=%0d ws=%0d",
                   cyc - t0, ws, e.off, e.val);
        end
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL stop_timeout: %0d word ends missing, expected 0", exp_q.size());
    end
    tick();
    n_checks++;
    if ({sck, ws, sck_oe, ws_oe, busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL stop_lines_parked: sck,ws,sck_oe,ws_oe,busy=%b, expected 00000",
               {sck, ws, sck_oe, ws_oe, busy});
    end
    repeat (4) begin
      tick();
      if (fall) falls++;
    end
    n_checks++;
    if (falls != 16) begin
      n_fail++;
      $display("FAIL stop_fall_count: got %0d, expected 16", falls);
    end
  endtask

  task automatic test_cfg_isolation_restart();
    exp_t e;
    int t0, n, idle;
    bit ok;
    exp_q.delete();
    div = 1; wlen = 3; dly = 0; en = 1'b1;
    for (int j = 1; j <= 4; j++) push(EV_RISE, 4 * j, 0);
    tick();
    t0 = cyc; n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      tick();
      n++;
      if (cyc - t0 == 5) begin
        div = 5; wlen = 7; dly = 1;
      end
      if (rise && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (cyc - t0 != e.off) begin
          n_fail++;
          $display("FAIL isolation_rise: offset=%0d, expected %0d", cyc - t0, e.off);
        end
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL isolation_timeout: %0d rises missing, expected 0", exp_q.size());
    end
    // One-cycle enable drop, then re-assert while stopping: must be ignored
    // until the first IDLE cycle, which is followed directly by START.
    en = 1'b0;
    tick();
    en = 1'b1;
    wait_idle(200, ok);
    idle = 0; n = 0;
    while (!busy && n < 50) begin
      idle++;
      tick();
      n++;
    end
    n_checks++;
    if (!ok || idle != 1) begin
      n_fail++;
      $display("FAIL restart_idle_cycles: got %0d (stopped=%0d), expected 1", idle, ok);
    end
    t0 = cyc; n = 0;
    for (int j = 1; j <= 3; j++) push(EV_RISE, 12 * j, 0);
    while (exp_q.size() > 0 && n < 200) begin
      tick();
      n++;
      if (rise && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (cyc - t0 != e.off) begin
          n_fail++;
          $display("FAIL restart_rise: offset=%0d, expected %0d", cyc - t0, e.off);
        end
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL restart_timeout: %0d rises missing, expected 0", exp_q.size());
    end
    en = 1'b0;
    wait_idle(800, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL restart_stop: busy=%b, expected 0", busy);
    end
  endtask

  task automatic test_wlen0_start_drop();
    exp_t e;
    int t0, n, falls, wends;
    exp_q.delete();
    div = 0; wlen = 0; dly = 0; en = 1'b1;
    push(EV_WE, 5, 1);
    push(EV_WE, 9, 0);
    tick();
    t0 = cyc;
    en = 1'b0;
    n = 0; falls = 0; wends = 0;
    while (n < 20) begin
      tick();
      n++;
      if (fall) falls++;
      if (wend) begin
        wends++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          n_checks++;
          if (cyc - t0 != e.off || int'(ws) != e.val) begin
            n_fail++;
            $display("FAIL wlen0_word_end: offset=%0d ws=%b, expected offset=%0d ws=%0d",
                     cyc - t0, ws, e.off, e.val);
          end
        end
      end
    end
    n_checks++;
    if (falls != 4 || wends != 2 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL start_drop_frame: falls=%0d word_ends=%0d busy=%b, expected 4 2 0",
               falls, wends, busy);
    end
  endtask

  task automatic test_async_reset();
    int n;
    bit ok;
    div = 2; wlen = 3; dly = 0; en = 1'b1;
    tick();
    n = 0;
    while (sck !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    n_checks++;
    if (sck !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_sck_high: sck=%b, expected 1", sck);
    end
    #3;
    rstn = 1'b0;
    #1;
    n_checks++;
    if ({sck, sck_oe, ws, ws_oe, busy, rise, fall, wend} !== 8'b0) begin
      n_fail++;
      $display("FAIL areset_immediate: outputs=%b, expected 00000000",
               {sck, sck_oe, ws, ws_oe, busy, rise, fall, wend});
    end
    en = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    repeat (4) tick();
    n_checks++;
    if (busy !== 1'b0 || sck_oe !== 1'b0 || sck !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_idle: busy=%b sck_oe=%b sck=%b, expected 0 0 0", busy, sck_oe, sck);
    end
    en = 1'b1;
    tick();
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_restart: busy=%b, expected 1", busy);
    end
    en = 1'b0;
    wait_idle(400, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL areset_stop: busy=%b, expected 0", busy);
    end
  endtask

`ifdef I2S_FRAME_CNT_EN
  task automatic test_frame_count();
    exp_t e;
    int t0, n, falls;
    bit ok;
    exp_q.delete();
    div = 0; wlen = 3; dly = 0; frames = 16'd3; en = 1'b1;
    for (int j = 1; j <= 6; j++) push(EV_WE, 1 + 8 * j, j / 2);
    tick();
    t0 = cyc; n = 0; falls = 0;
    while (busy && n < 200) begin
      tick();
      n++;
      if (fall) falls++;
      if (wend && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (cyc - t0 != e.off || int'(fcnt) != e.val) begin
          n_fail++;
          $display("FAIL frames_word_end: offset=%0d frame_cnt=%0d, expected offset=%0d frame_cnt=%0d",
                   cyc - t0, fcnt, e.off, e.val);
        end
      end
    end
    n_checks++;
    if (falls != 24 || fcnt !== 16'd3 || busy !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL frames_auto_stop: falls=%0d frame_cnt=%0d busy=%b left=%0d, expected 24 3 0 0",
               falls, fcnt, busy, exp_q.size());
    end
    repeat (5) tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL frames_no_restart: busy=%b, expected 0", busy);
    end
    en = 1'b0;
    tick();
    en = 1'b1;
    tick();
    n_checks++;
    if (busy !== 1'b1 || fcnt !== 16'd0) begin
      n_fail++;
      $display("FAIL frames_restart: busy=%b frame_cnt=%0d, expected 1 0", busy, fcnt);
    end
    en = 1'b0;
    frames = 16'd0;
    wait_idle(200, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL frames_stop: busy=%b, expected 0", busy);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_divider();
    test_philips();
    test_clean_stop();
    test_cfg_isolation_restart();
    test_wlen0_start_drop();
    test_async_reset();
`ifdef I2S_FRAME_CNT_EN
    test_frame_count();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_master_clkgen.md
Name: i2s_master_clkgen

Overview:
- Sequencer for the master-side I2S clock and word-select lines: generates SCK from the system clock via a programmable divider and WS from a bit counter.
- Controls the output-enable bits for both lines.
- Issues per-bit strobes and word-end strobes so the uDMA I2S TX/RX datapath can launch and sample data.
- Sits between the uDMA I2S register file and the master_sck/master_sck_oe/master_ws/master_ws_oe fields of the pad structure.

Parameters:
- DIV_W, 16: width of the clock divider configuration.
- WLEN_W, 5: width of the word-length configuration (word length up to 32 bits).

Ports:
- clk_i  input  1  system clock
- rstn_i  input  1  asynchronous active-low reset
- cfg_en_i  input  1  run request; level-sensitive
- cfg_div_i  input  DIV_W  SCK half-period minus 1, in clk_i cycles
- cfg_wlen_i  input  WLEN_W  bits per word minus 1
- cfg_ws_dly_i  input  1  1 = Philips I2S (WS leads MSB by one bit), 0 = left-justified
- sck_o  output  1  to master_sck
- sck_oe_o  output  1  to master_sck_oe
- ws_o  output  1  to master_ws
- ws_oe_o  output  1  to master_ws_oe
- busy_o  output  1  high in any state other than IDLE
- bit_rise_o  output  1  1-cycle pulse, cycle in which sck_o goes 0->1 (sample point)
- bit_fall_o  output  1  1-cycle pulse, cycle in which sck_o goes 1->0 (launch point)
- word_end_o  output  1  1-cycle pulse on the falling edge that ends a word

Behaviour:
- Reset values: all outputs 0, state IDLE, all counters 0. Reset is asynchronous mid-operation: lines drop immediately and no stop sequence runs.
- States are IDLE, START, RUN, STOP.
- IDLE:
  - sck_o = ws_o = 0; both OEs = 0; busy_o = 0.
  - cfg_en_i = 1 -> latch div, wlen and ws_dly, set both OEs = 1, clear the divider counter, go to START.
  - Configuration changes outside IDLE are ignored.
- START: hold sck_o = 0 for one full half-period (div+1 cycles), then go to RUN.
- Divider:
  - Counter runs 0..div. At the terminal count, sck_o toggles and the counter returns to 0.
  - SCK period = 2*(div+1) clk_i cycles; div = 0 gives clk_i/2.
- Strobes and the sck_o edge are registered together: a strobe is high in the same cycle sck_o shows the new level.
- Bit counter:
  - Increments on each SCK falling edge and wraps wlen -> 0.
  - The wrap edge asserts word_end_o.
- WS timing:
  - ws_dly = 0: ws_o toggles on the wrap edge.
  - ws_dly = 1: ws_o toggles on the falling edge where the counter goes wlen-1 -> wlen, i.e. one bit before the wrap.
- Word order: ws_o = 0 is the left word, 1 is the right word. The first word after START is the left word.
- cfg_en_i = 0 in RUN -> go to STOP.
- STOP:
  - SCK keeps running until the right word (ws_o = 1 at word start) completes.
  - At that word_end_o edge: sck_o stays 0, ws_o is forced to 0, OEs drop, go to IDLE.
  - cfg_en_i reasserted during STOP is ignored. If cfg_en_i is still high on the first IDLE cycle, START is re-entered on the next cycle (one IDLE cycle minimum).
- If cfg_en_i drops during START, the block enters RUN and then immediately enters STOP; one full frame is always produced.
- Minimum wlen is 1. wlen = 0 is treated as 1.

Optional Feature:
- Macro: I2S_FRAME_CNT_EN.
- Defined:
  - Adds input cfg_frames_i[15:0] (latched in IDLE) and output frame_cnt_o[15:0].
  - frame_cnt_o is cleared in START and increments on every right-word word_end_o.
  - If cfg_frames_i != 0, the block enters STOP automatically once frame_cnt_o reaches cfg_frames_i, regardless of cfg_en_i, and goes to IDLE at that frame end.
  - The block does not restart until cfg_en_i has been low for at least one cycle.
- Undefined: the ports are absent and the block runs until cfg_en_i falls.

Test Plan:
- Divider check: div = 0, wlen = 15, ws_dly = 0, en = 1 -> SCK period 2 cycles; first rise 2 cycles after START entry; word_end_o every 32 cycles; ws_o toggles at each word_end_o.
- Philips timing: div = 3, wlen = 7, ws_dly = 1 -> ws_o toggles 8 cycles (one SCK period) before each word_end_o; 16 bit_rise_o pulses per frame.
- Clean stop: drop en during left word bit 3, wlen = 7 -> right word completes (16 total falls in that frame), then sck_o = ws_o = 0, OEs = 0, busy_o = 0 the cycle after the final word_end_o.
- Config isolation and restart: change div from 1 to 5 mid-RUN -> period stays 4 cycles; after stop and re-enable, period is 12 cycles; exactly one IDLE cycle is observed between runs if en is held.
- Async reset: assert rstn_i while sck_o = 1 in RUN -> all outputs 0 without waiting for a clk_i edge; after release the block sits in IDLE until en.
- With I2S_FRAME_CNT_EN: frames = 3, wlen = 3, en held high -> frame_cnt_o reaches 3, block auto-stops after 24 falling edges, busy_o = 0, no restart until en toggles low then high.
